// File: rtl/act_table.sv
`default_nettype none
// ============================================================================
// Module   : act_table
// Purpose  : Per-block core access table with a 1-cycle read port and a
//            range-update config FSM. Optional sticky lock: ACT_CFG_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module act_table #(
    parameter int NUM_CORES        = 4,
    parameter int CORE_ID_WIDTH    = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int BLOCK_COUNT_BITS = 4,
    parameter int REGION_SHIFT     = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        act_cs,
    input  logic [BLOCK_COUNT_BITS-1:0] act_addr,
    output logic [2*NUM_CORES-1:0]      act_rdata,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ADDR_WIDTH-1:0]       cfg_base,
    input  logic [BLOCK_COUNT_BITS:0]   cfg_count,
    input  logic [CORE_ID_WIDTH-1:0]    cfg_core,
    input  logic                        cfg_rd_en,
    input  logic                        cfg_wr_en,
    input  logic                        cfg_lock,
    output logic                        cfg_done,
    output logic                        cfg_err
);

    localparam int DEPTH = 2**BLOCK_COUNT_BITS;
    localparam int EW    = 2*NUM_CORES;
    localparam logic [BLOCK_COUNT_BITS-1:0] IDX_ONE   = {{(BLOCK_COUNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [BLOCK_COUNT_BITS:0]   REM_ONE   = {{BLOCK_COUNT_BITS{1'b0}}, 1'b1};
    localparam logic [BLOCK_COUNT_BITS+1:0] DEPTH_END = {2'b01, {BLOCK_COUNT_BITS{1'b0}}};

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_UPDATE = 2'd1,
        CFG_DONE   = 2'd2
    } cfg_state_e;

    cfg_state_e                  state_q, state_d;
    logic [EW-1:0]               table_q [DEPTH];
    logic [EW-1:0]               table_d [DEPTH];
    logic [EW-1:0]               act_rdata_q, act_rdata_d;
    logic [BLOCK_COUNT_BITS-1:0] idx_q, idx_d;
    logic [BLOCK_COUNT_BITS:0]   rem_q, rem_d;
    logic [CORE_ID_WIDTH-1:0]    core_q, core_d;
    logic                        rd_q, rd_d;
    logic                        wr_q, wr_d;
    logic                        err_q, err_d;

    logic [BLOCK_COUNT_BITS-1:0] req_idx;
    logic [BLOCK_COUNT_BITS+1:0] req_end;
    logic                        req_err;
    logic [NUM_CORES-1:0]        rmask, wmask;
    logic                        unused_bits;

`ifdef ACT_CFG_LOCK_EN
    logic lock_q, lock_d;
    logic locked_q, locked_d;
`endif

    assign req_idx     = cfg_base[REGION_SHIFT +: BLOCK_COUNT_BITS];
    // End bound is computed two bits wider so idx+count can never wrap.
    assign req_end     = {2'b00, req_idx} + {1'b0, cfg_count};
    assign unused_bits = ^{cfg_base, cfg_lock};

`ifdef ACT_CFG_LOCK_EN
    assign req_err = (cfg_count == '0) || (req_end > DEPTH_END) || locked_q;
`else
    assign req_err = (cfg_count == '0) || (req_end > DEPTH_END);
`endif

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        core_d      = core_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        err_d       = err_q;
        rmask       = table_q[idx_q][NUM_CORES-1:0];
        wmask       = table_q[idx_q][EW-1:NUM_CORES];
`ifdef ACT_CFG_LOCK_EN
        lock_d      = lock_q;
        locked_d    = locked_q;
`endif
        // Reads see table_q, so a same-edge write returns the old entry.
        act_rdata_d = act_cs ? table_q[act_addr] : act_rdata_q;

        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    idx_d   = req_idx;
                    rem_d   = cfg_count;
                    core_d  = cfg_core;
                    rd_d    = cfg_rd_en;
                    wr_d    = cfg_wr_en;
                    err_d   = req_err;
`ifdef ACT_CFG_LOCK_EN
                    lock_d  = cfg_lock;
`endif
                    state_d = req_err ? CFG_DONE : CFG_UPDATE;
                end
            end
            CFG_UPDATE: begin
                rmask[core_q]  = rd_q;
                wmask[core_q]  = wr_q;
                table_d[idx_q] = {wmask, rmask};
                idx_d          = idx_q + IDX_ONE;
                rem_d          = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    state_d = CFG_DONE;
`ifdef ACT_CFG_LOCK_EN
                    locked_d = locked_q | lock_q;
`endif
                end
            end
            CFG_DONE: state_d = CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CFG_IDLE;
            table_q     <= '{default: '0};
            act_rdata_q <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            core_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
`ifdef ACT_CFG_LOCK_EN
            lock_q      <= 1'b0;
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            act_rdata_q <= act_rdata_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            core_q      <= core_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
`ifdef ACT_CFG_LOCK_EN
            lock_q      <= lock_d;
            locked_q    <= locked_d;
`endif
        end
    end

    assign act_rdata = act_rdata_q;
    assign cfg_ready = (state_q == CFG_IDLE);
    assign cfg_done  = (state_q == CFG_DONE);
    assign cfg_err   = (state_q == CFG_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_act_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_table
// Purpose  : Directed self-checking bench for act_table (both lock builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        act_cs = 1'b0;
    logic [3:0]  act_addr = '0;
    logic [7:0]  act_rdata;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_base = '0;
    logic [4:0]  cfg_count = '0;
    logic [1:0]  cfg_core = '0;
    logic        cfg_rd_en = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_lock = 1'b0;
    logic        cfg_done;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    act_table #(
        .NUM_CORES(4), .CORE_ID_WIDTH(2), .ADDR_WIDTH(32),
        .BLOCK_COUNT_BITS(4), .REGION_SHIFT(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .act_cs(act_cs), .act_addr(act_addr), .act_rdata(act_rdata),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base(cfg_base),
        .cfg_count(cfg_count), .cfg_core(cfg_core), .cfg_rd_en(cfg_rd_en),
        .cfg_wr_en(cfg_wr_en), .cfg_lock(cfg_lock),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_blk(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        act_cs   = 1'b1;
        act_addr = a;
        @(negedge clk);
        d      = act_rdata;
        act_cs = 1'b0;
    endtask

    // Issues one request; n = cycles from acceptance to cfg_done (inclusive).
    task automatic request(input logic [31:0] base, input logic [4:0] cnt,
                           input logic [1:0] core, input logic rd, input logic wr,
                           input logic lk, output int n, output int low,
                           output logic err);
        logic got;
        @(negedge clk);
        cfg_base = base; cfg_count = cnt; cfg_core = core;
        cfg_rd_en = rd; cfg_wr_en = wr; cfg_lock = lk; cfg_valid = 1'b1;
        for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
        n = 0; low = 0; err = 1'bx; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            n++;
            if (!cfg_ready) low++;
            if (cfg_done) begin
                got = 1'b1;
                err = cfg_err;
            end
        end
    endtask

    logic [7:0] d;
    logic       e;
    int         n, low;
    logic       seen_done;

    initial begin
        #2;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_rdata", 32'(act_rdata), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        read_blk(4'd3, d);
        check("rd_blk3_reset", 32'(d), 32'h00);

        // 3-block update at block 2, core 1 read bit
        request(32'h2000, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, n, low, e);
        check("upd3_latency", 32'(n), 32'd4);
        check("upd3_ready_low", 32'(low), 32'd4);
        check("upd3_err", 32'(e), 32'd0);
        @(negedge clk);
        check("upd3_ready_back", 32'(cfg_ready), 32'd1);
        read_blk(4'd1, d); check("upd3_blk1", 32'(d), 32'h00);
        read_blk(4'd2, d); check("upd3_blk2", 32'(d), 32'h02);
        read_blk(4'd3, d); check("upd3_blk3", 32'(d), 32'h02);
        read_blk(4'd4, d); check("upd3_blk4", 32'(d), 32'h02);
        read_blk(4'd5, d); check("upd3_blk5", 32'(d), 32'h00);

        // act_rdata holds while act_cs is low
        act_addr = 4'd3;
        @(negedge clk);
        check("rd_hold", 32'(act_rdata), 32'h00);

        // Out-of-range and zero-count requests
        request(32'hE000, 5'd3, 2'd3, 1'b1, 1'b1, 1'b0, n, low, e);
        check("oob_latency", 32'(n), 32'd1);
        check("oob_err", 32'(e), 32'd1);
        read_blk(4'd14, d); check("oob_blk14", 32'(d), 32'h00);
        read_blk(4'd15, d); check("oob_blk15", 32'(d), 32'h00);
        request(32'h0000, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, n, low, e);
        check("zero_latency", 32'(n), 32'd1);
        check("zero_err", 32'(e), 32'd1);

        // Exact fit up to the last block
        request(32'hE000, 5'd2, 2'd3, 1'b1, 1'b1, 1'b0, n, low, e);
        check("fit_latency", 32'(n), 32'd3);
        check("fit_err", 32'(e), 32'd0);
        read_blk(4'd15, d); check("fit_blk15", 32'(d), 32'h88);
        read_blk(4'd0, d);  check("fit_blk0", 32'(d), 32'h00);

        // Read and write of block 2 at the same edge
        @(negedge clk);
        cfg_base = 32'h2000; cfg_count = 5'd1; cfg_core = 2'd0;
        cfg_rd_en = 1'b0; cfg_wr_en = 1'b1; cfg_lock = 1'b0; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        act_cs = 1'b1; act_addr = 4'd2;
        @(negedge clk);
        act_cs = 1'b0;
        check("rw_old_value", 32'(act_rdata), 32'h02);
        check("rw_done", 32'(cfg_done), 32'd1);
        read_blk(4'd2, d); check("rw_new_value", 32'(d), 32'h12);

        // Lock request then a follow-up request
        request(32'h0000, 5'd1, 2'd0, 1'b1, 1'b1, 1'b1, n, low, e);
        check("lock_req_err", 32'(e), 32'd0);
        read_blk(4'd0, d); check("lock_blk0", 32'(d), 32'h11);
        request(32'h1000, 5'd1, 2'd2, 1'b1, 1'b0, 1'b0, n, low, e);
        read_blk(4'd1, d);
`ifdef ACT_CFG_LOCK_EN
        check("locked_err", 32'(e), 32'd1);
        check("locked_blk1", 32'(d), 32'h00);
`else
        check("nolock_err", 32'(e), 32'd0);
        check("nolock_blk1", 32'(d), 32'h04);
`endif

        // Reset in the middle of an 8-block update
        @(negedge clk);
        cfg_base = 32'h0000; cfg_count = 5'd8; cfg_core = 2'd1;
        cfg_rd_en = 1'b1; cfg_wr_en = 1'b1; cfg_lock = 1'b0; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(cfg_ready), 32'd1);
        check("abort_done", 32'(cfg_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cfg_done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_ready_after", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            read_blk(4'(i), d);
            check($sformatf("abort_blk%0d", i), 32'(d), 32'h00);
        end

        // Reset clears any lock
        request(32'h1000, 5'd1, 2'd2, 1'b1, 1'b0, 1'b0, n, low, e);
        check("post_rst_err", 32'(e), 32'd0);
        read_blk(4'd1, d); check("post_rst_blk1", 32'(d), 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
